// File: rtl/glitch_scheduler.sv
// Voltage-glitch sequencer: arms on command, triggers on a matching sniffed I2C byte,
// then drives delay / width / gap / repeat timing onto a registered DAC level.
module glitch_scheduler #(
  parameter int              DW        = 8,
  parameter int              CW        = 32,
  parameter logic [DW-1:0]   RST_LEVEL = 8'h00
) (
  input  logic          i_clk,
  input  logic          i_reset,          // asynchronous, active-low
  input  logic          i_arm,
  input  logic          i_abort,
  input  logic [1:0]    i_src_en,
  input  logic [8:0]    i_priv_byte,
  input  logic          i_priv_ready,
  input  logic [8:0]    i_main_byte,
  input  logic          i_main_ready,
  input  logic [7:0]    i_match_byte,
  input  logic [CW-1:0] i_delay,
  input  logic [CW-1:0] i_width,
  input  logic [CW-1:0] i_gap,
  input  logic [7:0]    i_repeats,
  input  logic [DW-1:0] i_glitch_level,
  input  logic [DW-1:0] i_nominal_level,
  output logic [DW-1:0] o_dac_level,
  output logic          o_busy,
  output logic          o_fired,
  output logic          o_done,
  output logic          o_trig_src,
  output logic [7:0]    o_glitch_count,
  output logic [3:0]    o_state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ARMED  = 4'd1,
    S_DELAY  = 4'd2,
    S_GLITCH = 4'd3,
    S_GAP    = 4'd4,
    S_DONE   = 4'd5
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_delay, r_width, r_gap;
  logic [7:0]    r_repeats, r_match;
  logic [1:0]    r_src_en;
  logic [DW-1:0] r_glitch_lvl, r_nom_lvl;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [DW-1:0] r_dac, w_dac_nxt;
  logic          r_fired, w_fired_nxt;
  logic          r_done, w_done_nxt;
  logic          r_trig_src, w_trig_src_nxt;
  logic [7:0]    r_glitch_count, w_count_nxt;
  logic          w_latch;
  logic          w_go_glitch;

  logic          w_priv_hit, w_main_hit;
  logic [CW-1:0] w_width_eff, w_gap_eff;
  logic [7:0]    w_rep_eff, w_count_inc;

  // Zero-valued loads behave as one so no counter ever wraps.
  assign w_width_eff = (r_width == '0) ? CW'(1) : r_width;
  assign w_gap_eff   = (r_gap == '0) ? CW'(1) : r_gap;
  assign w_rep_eff   = (r_repeats == 8'd0) ? 8'd1 : r_repeats;
  assign w_count_inc = (r_glitch_count == 8'hFF) ? 8'hFF : r_glitch_count + 8'd1;

  assign w_priv_hit = i_priv_ready & r_src_en[0] & (i_priv_byte[8:1] == r_match);
  assign w_main_hit = i_main_ready & r_src_en[1] & (i_main_byte[8:1] == r_match);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_dac_nxt      = r_nom_lvl;
    w_fired_nxt    = 1'b0;
    w_done_nxt     = 1'b0;
    w_trig_src_nxt = r_trig_src;
    w_count_nxt    = r_glitch_count;
    w_latch        = 1'b0;
    w_go_glitch    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_dac_nxt = i_nominal_level;
        if (i_arm && !i_abort) begin
          w_latch     = 1'b1;
          w_count_nxt = 8'd0;
          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (w_priv_hit || w_main_hit) begin
          w_trig_src_nxt = ~w_priv_hit;
          if (r_delay == '0) begin
            w_go_glitch = 1'b1;
          end else begin
            w_state_nxt = S_DELAY;
            w_cnt_nxt   = r_delay;
          end
        end
      end
      S_DELAY: begin
        if (r_cnt <= CW'(1)) w_go_glitch = 1'b1;
        else                 w_cnt_nxt   = r_cnt - CW'(1);
      end
      S_GLITCH: begin
        w_dac_nxt = r_glitch_lvl;
        if (r_cnt <= CW'(1)) begin
          w_dac_nxt = r_nom_lvl;
          if (r_glitch_count < w_rep_eff) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = w_gap_eff;
          end else begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_GAP: begin
        if (r_cnt <= CW'(1)) w_go_glitch = 1'b1;
        else                 w_cnt_nxt   = r_cnt - CW'(1);
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Common entry into a glitch pulse from ARMED, DELAY or GAP.
    if (w_go_glitch) begin
      w_state_nxt = S_GLITCH;
      w_cnt_nxt   = w_width_eff;
      w_dac_nxt   = r_glitch_lvl;
      w_fired_nxt = 1'b1;
      w_count_nxt = w_count_inc;
    end

    // Abort overrides everything outside IDLE; the pulse count is kept for inspection.
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_nxt    = S_IDLE;
      w_cnt_nxt      = '0;
      w_dac_nxt      = r_nom_lvl;
      w_fired_nxt    = 1'b0;
      w_done_nxt     = 1'b0;
      w_count_nxt    = r_glitch_count;
      w_trig_src_nxt = r_trig_src;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_dac          <= RST_LEVEL;
      r_fired        <= 1'b0;
      r_done         <= 1'b0;
      r_trig_src     <= 1'b0;
      r_glitch_count <= 8'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_dac          <= w_dac_nxt;
      r_fired        <= w_fired_nxt;
      r_done         <= w_done_nxt;
      r_trig_src     <= w_trig_src_nxt;
      r_glitch_count <= w_count_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_delay      <= '0;
      r_width      <= '0;
      r_gap        <= '0;
      r_repeats    <= 8'd0;
      r_match      <= 8'd0;
      r_src_en     <= 2'b00;
      r_glitch_lvl <= '0;
      r_nom_lvl    <= '0;
    end else if (w_latch) begin
      r_delay      <= i_delay;
      r_width      <= i_width;
      r_gap        <= i_gap;
      r_repeats    <= i_repeats;
      r_match      <= i_match_byte;
      r_src_en     <= i_src_en;
      r_glitch_lvl <= i_glitch_level;
      r_nom_lvl    <= i_nominal_level;
    end
  end

  assign o_dac_level    = r_dac;
  assign o_busy         = (r_state != S_IDLE);
  assign o_fired        = r_fired;
  assign o_done         = r_done;
  assign o_trig_src     = r_trig_src;
  assign o_glitch_count = r_glitch_count;
  assign o_state        = r_state;

endmodule

// File: tb/tb_glitch_scheduler.sv
// Bench for glitch_scheduler: directed scenarios plus randomized sequences checked
// against a timeline model computed from pulse arithmetic (start = T+1+delay+k*(W+G)).
module tb_glitch_scheduler;
  localparam int         DW      = 8;
  localparam int         CW      = 32;
  localparam logic [7:0] RST_LVL = 8'h5A;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_arm, i_abort;
  logic [1:0]    i_src_en;
  logic [8:0]    i_priv_byte, i_main_byte;
  logic          i_priv_ready, i_main_ready;
  logic [7:0]    i_match_byte;
  logic [CW-1:0] i_delay, i_width, i_gap;
  logic [7:0]    i_repeats;
  logic [DW-1:0] i_glitch_level, i_nominal_level;
  logic [DW-1:0] o_dac_level;
  logic          o_busy, o_fired, o_done, o_trig_src;
  logic [7:0]    o_glitch_count;
  logic [3:0]    o_state;

  int n_checks = 0;
  int n_fail   = 0;

  glitch_scheduler #(.DW(DW), .CW(CW), .RST_LEVEL(RST_LVL)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_arm(i_arm), .i_abort(i_abort),
    .i_src_en(i_src_en), .i_priv_byte(i_priv_byte), .i_priv_ready(i_priv_ready),
    .i_main_byte(i_main_byte), .i_main_ready(i_main_ready), .i_match_byte(i_match_byte),
    .i_delay(i_delay), .i_width(i_width), .i_gap(i_gap), .i_repeats(i_repeats),
    .i_glitch_level(i_glitch_level), .i_nominal_level(i_nominal_level),
    .o_dac_level(o_dac_level), .o_busy(o_busy), .o_fired(o_fired), .o_done(o_done),
    .o_trig_src(o_trig_src), .o_glitch_count(o_glitch_count), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic bus_quiet();
    i_priv_ready = 1'b0;
    i_main_ready = 1'b0;
  endtask

  task automatic load_cfg(input int d, input int w, input int g, input int r,
                          input logic [1:0] en, input logic [7:0] m,
                          input logic [7:0] gl, input logic [7:0] nl);
    i_delay = CW'(d); i_width = CW'(w); i_gap = CW'(g); i_repeats = 8'(r);
    i_src_en = en; i_match_byte = m; i_glitch_level = gl; i_nominal_level = nl;
  endtask

  // Arms, scrambles live config, waits with noise, triggers on the buses in mask,
  // then walks the expected timeline cycle by cycle.
  task automatic run_seq(input int d, input int w, input int g, input int r,
                         input logic [1:0] en, input logic [1:0] mask,
                         input logic [7:0] m, input logic [7:0] gl,
                         input logic [7:0] nl, input int pre);
    int   wp, gp, rp, per, last, u, k;
    logic active, exp_src;
    logic [7:0] b;
    wp   = (w == 0) ? 1 : w;
    gp   = (g == 0) ? 1 : g;
    rp   = (r == 0) ? 1 : r;
    per  = wp + gp;
    last = d + (rp - 1) * per + wp;
    exp_src = ((mask & en & 2'b01) != 2'b00) ? 1'b0 : 1'b1;

    load_cfg(d, w, g, r, en, m, gl, nl);
    i_arm = 1'b1;
    i_priv_byte = {m, 1'b0}; i_priv_ready = en[0];
    i_main_byte = {m, 1'b1}; i_main_ready = en[1];
    step();
    i_arm = 1'b0;
    bus_quiet();
    chk("arm_state", 32'(o_state), 32'd1);
    chk("arm_busy", 32'(o_busy), 32'd1);
    chk("arm_count", 32'(o_glitch_count), 32'd0);

    i_delay = CW'(d + 7); i_width = CW'(w + 3); i_gap = CW'(g + 2);
    i_repeats = 8'(r + 1); i_match_byte = ~m; i_glitch_level = ~gl; i_src_en = ~en;

    for (int p = 0; p < pre; p++) begin
      b = 8'($urandom);
      if (b == m) b = b + 8'd1;
      i_priv_byte = {b, 1'($urandom)}; i_priv_ready = 1'($urandom_range(0, 1));
      b = 8'($urandom);
      if (b == m) b = b + 8'd1;
      i_main_byte = {b, 1'($urandom)}; i_main_ready = 1'($urandom_range(0, 1));
      if (!en[0] && $urandom_range(0, 1) == 1) begin
        i_priv_byte = {m, 1'b1}; i_priv_ready = 1'b1;
      end
      if (!en[1] && $urandom_range(0, 1) == 1) begin
        i_main_byte = {m, 1'b0}; i_main_ready = 1'b1;
      end
      i_arm = 1'($urandom_range(0, 1));
      step();
      i_arm = 1'b0;
      bus_quiet();
      chk("wait_state", 32'(o_state), 32'd1);
      chk("wait_dac", 32'(o_dac_level), 32'(nl));
    end

    i_priv_byte = {m, 1'($urandom)}; i_priv_ready = mask[0];
    i_main_byte = {m, 1'($urandom)}; i_main_ready = mask[1];
    for (int t = 1; t <= last + 2; t++) begin
      step();
      bus_quiet();
      active = (t >= 1 + d) && (t <= last);
      u = t - 1 - d;
      k = active ? (u % per) : per;
      chk("seq_dac", 32'(o_dac_level), 32'((active && k < wp) ? gl : nl));
      chk("seq_fired", 32'(o_fired), 32'(active && k == 0));
      chk("seq_done", 32'(o_done), 32'(t == last + 1));
      chk("seq_busy", 32'(o_busy), 32'(t <= last + 1));
      chk("seq_count", 32'(o_glitch_count),
          (t < 1 + d) ? 32'd0 : (t > last) ? 32'(rp) : 32'(u / per + 1));
      if ($urandom_range(0, 2) == 0) begin
        i_priv_byte = {m, 1'b0}; i_priv_ready = 1'b1;
        i_main_byte = {m, 1'b1}; i_main_ready = 1'b1;
      end
    end
    chk("seq_state_end", 32'(o_state), 32'd0);
    chk("seq_trig_src", 32'(o_trig_src), 32'(exp_src));
    i_nominal_level = nl;
  endtask

  initial begin
    logic [7:0] gl, nl;
    logic [1:0] en, mask;

    i_reset = 1'b0; i_arm = 1'b0; i_abort = 1'b0;
    i_priv_byte = '0; i_main_byte = '0;
    bus_quiet();
    load_cfg(0, 0, 0, 0, 2'b00, 8'h00, 8'hC0, 8'h40);
    #12;
    chk("rst_dac", 32'(o_dac_level), 32'(RST_LVL));
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_fired", 32'(o_fired), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_trig_src", 32'(o_trig_src), 32'd0);
    chk("rst_count", 32'(o_glitch_count), 32'd0);
    i_reset = 1'b1;
    step();
    chk("idle_dac", 32'(o_dac_level), 32'h40);

    // arm together with abort in IDLE is ignored
    i_arm = 1'b1; i_abort = 1'b1;
    step();
    i_arm = 1'b0; i_abort = 1'b0;
    chk("arm_abort_state", 32'(o_state), 32'd0);

    // no enabled source: stays armed regardless of matches
    load_cfg(0, 1, 1, 1, 2'b00, 8'h33, 8'hC0, 8'h40);
    i_arm = 1'b1;
    step();
    i_arm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_priv_byte = {8'h33, 1'b1}; i_priv_ready = 1'b1;
      i_main_byte = {8'h33, 1'b1}; i_main_ready = 1'b1;
      step();
      bus_quiet();
      chk("noen_state", 32'(o_state), 32'd1);
    end
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("noen_abort_state", 32'(o_state), 32'd0);
    chk("noen_abort_done", 32'(o_done), 32'd0);

    // directed scenarios
    run_seq(10, 4, 0, 1, 2'b01, 2'b01, 8'h6A, 8'hF0, 8'h40, 2);
    run_seq(0, 0, 0, 0, 2'b01, 2'b01, 8'h12, 8'hE1, 8'h20, 1);
    run_seq(3, 2, 1, 1, 2'b11, 2'b11, 8'h77, 8'hAA, 8'h55, 2);
    run_seq(1, 1, 1, 1, 2'b10, 2'b10, 8'h5C, 8'h99, 8'h11, 4);
    run_seq(0, 2, 5, 3, 2'b01, 2'b01, 8'h81, 8'hFF, 8'h00, 0);

    // abort in the second glitch cycle
    load_cfg(0, 4, 1, 1, 2'b01, 8'h3C, 8'hD0, 8'h30);
    i_arm = 1'b1;
    step();
    i_arm = 1'b0;
    i_priv_byte = {8'h3C, 1'b1}; i_priv_ready = 1'b1;
    step();
    bus_quiet();
    chk("abort_fired", 32'(o_fired), 32'd1);
    step();
    chk("abort_pre_dac", 32'(o_dac_level), 32'hD0);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("abort_dac", 32'(o_dac_level), 32'h30);
    chk("abort_state", 32'(o_state), 32'd0);
    chk("abort_count", 32'(o_glitch_count), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_done", 32'(o_done), 32'd0);
      step();
    end
    run_seq(2, 3, 2, 2, 2'b11, 2'b10, 8'h4E, 8'hB7, 8'h30, 1);

    // async reset mid-glitch after a main-bus trigger
    load_cfg(0, 6, 1, 2, 2'b10, 8'h21, 8'hEE, 8'h10);
    i_arm = 1'b1;
    step();
    i_arm = 1'b0;
    i_main_byte = {8'h21, 1'b0}; i_main_ready = 1'b1;
    step();
    bus_quiet();
    chk("mid_glitch_dac", 32'(o_dac_level), 32'hEE);
    chk("mid_glitch_src", 32'(o_trig_src), 32'd1);
    #2 i_reset = 1'b0;
    #1;
    chk("rst_glitch_dac", 32'(o_dac_level), 32'(RST_LVL));
    chk("rst_glitch_state", 32'(o_state), 32'd0);
    chk("rst_glitch_fired", 32'(o_fired), 32'd0);
    chk("rst_glitch_count", 32'(o_glitch_count), 32'd0);
    chk("rst_glitch_src", 32'(o_trig_src), 32'd0);
    chk("rst_glitch_busy", 32'(o_busy), 32'd0);
    #1 i_reset = 1'b1;
    step();

    // async reset mid-DELAY
    load_cfg(30, 2, 1, 1, 2'b01, 8'h42, 8'hEE, 8'h10);
    i_arm = 1'b1;
    step();
    i_arm = 1'b0;
    i_priv_byte = {8'h42, 1'b1}; i_priv_ready = 1'b1;
    step();
    bus_quiet();
    step();
    chk("delay_state", 32'(o_state), 32'd2);
    #2 i_reset = 1'b0;
    #1;
    chk("rst_delay_dac", 32'(o_dac_level), 32'(RST_LVL));
    chk("rst_delay_state", 32'(o_state), 32'd0);
    chk("rst_delay_busy", 32'(o_busy), 32'd0);
    #1 i_reset = 1'b1;
    step();

    // randomized sequences
    for (int n = 0; n < 10; n++) begin
      en   = 2'($urandom_range(1, 3));
      mask = en & 2'($urandom_range(1, 3));
      if (mask == 2'b00) mask = en;
      gl = 8'($urandom);
      nl = 8'($urandom);
      if (gl == nl) nl = ~gl;
      run_seq($urandom_range(0, 12), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), en, mask, 8'($urandom), gl, nl,
              $urandom_range(0, 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
